// File: rtl/iter_add_sched_pkg.sv
// Shared types and helpers for the iterative-adder scheduler.
// Optional feature macro: ITER_CNT_EN (adds the iteration counter and rsp_iter_o).
package iter_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width needed to hold an iteration count in [0, m]
    function automatic int unsigned iter_w(input int unsigned m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/iter_add_sched_if.sv
// Request/response bus between requesters and the shared adder scheduler.
// Optional feature macro: ITER_CNT_EN (adds rsp_iter_o).
interface iter_add_sched_if #(
    parameter int unsigned M   = 16,
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
);
    import iter_add_pkg::*;

    logic [N-1:0]   req_valid_i;
    logic [N*M-1:0] req_a_i;
    logic [N*M-1:0] req_b_i;
    logic [N-1:0]   req_ready_o;
    logic           rsp_valid_o;
    logic           rsp_ready_i;
    logic [IDW-1:0] rsp_id_o;
    logic [M-1:0]   rsp_sum_o;
    logic           rsp_cout_o;

`ifdef ITER_CNT_EN
    localparam int unsigned ITER_W = iter_w(M);
    logic [ITER_W-1:0] rsp_iter_o;

    modport master (
        output req_valid_i, req_a_i, req_b_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_cout_o, rsp_iter_o
    );
    modport slave (
        input  req_valid_i, req_a_i, req_b_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_cout_o, rsp_iter_o
    );
`else
    modport master (
        output req_valid_i, req_a_i, req_b_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_cout_o
    );
    modport slave (
        input  req_valid_i, req_a_i, req_b_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_cout_o
    );
`endif

endinterface

// File: rtl/iter_add_core.sv
// Carry-feedback adder core: one sum/carry exchange per step until carry is zero.
module iter_add_core #(
    parameter int unsigned M = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic         step,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] sum,
    output logic         carry_zero,
    output logic         cout
);

    logic [M-1:0] s_q;
    logic [M-1:0] c_q;
    logic         cout_q;
    logic [M-1:0] sc;
    logic [M-1:0] c_next;

    // Loading A/B raw makes the first step produce A^B and (A&B)<<1
    always_comb begin
        sc     = s_q & c_q;
        c_next = {sc[M-2:0], 1'b0};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            s_q    <= '0;
            c_q    <= '0;
            cout_q <= 1'b0;
        end else if (load) begin
            s_q    <= a;
            c_q    <= b;
            cout_q <= 1'b0;
        end else if (step) begin
            s_q    <= s_q ^ c_q;
            c_q    <= c_next;
            cout_q <= cout_q | sc[M-1];
        end
    end

    // Flags that the step taken this cycle leaves no carry behind
    assign carry_zero = (c_next == '0);
    assign sum        = s_q;
    assign cout       = cout_q;

endmodule

// File: rtl/iter_add_sched.sv
// Round-robin scheduler sharing one iterative adder core among N requesters.
// Optional feature macro: ITER_CNT_EN (iteration counter, saturating at M, on rsp_iter_o).
module iter_add_sched
    import iter_add_pkg::*;
#(
    parameter int unsigned M   = 16,
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    iter_add_sched_if.slave  bus,
    output logic             busy_o
);

    state_e         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_id;
    logic           gnt_any;
    logic [IDW-1:0] idx;
    logic [N-1:0]   ready;
    logic [IDW-1:0] rsp_id;
    logic           rsp_valid;
    logic [M-1:0]   op_a;
    logic [M-1:0]   op_b;
    logic [M-1:0]   core_sum;
    logic           core_carry_zero;
    logic           core_cout;
    logic           accept;
    logic           step;

`ifdef ITER_CNT_EN
    localparam int unsigned ITER_W = iter_w(M);
    logic [ITER_W-1:0] iter_cnt;
`endif

    // First valid requester at or after the round-robin pointer
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IDW'((32'(rr_ptr) + i) % N);
            if (!gnt_any && bus.req_valid_i[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state == IDLE && rst_i && gnt_any) begin
            ready[gnt_id] = 1'b1;
        end
    end

    assign accept = (state == IDLE) && gnt_any;
    assign step   = (state == ITER);
    assign op_a   = bus.req_a_i[32'(gnt_id) * M +: M];
    assign op_b   = bus.req_b_i[32'(gnt_id) * M +: M];

    iter_add_core #(.M(M)) u_core (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load       (accept),
        .step       (step),
        .a          (op_a),
        .b          (op_b),
        .sum        (core_sum),
        .carry_zero (core_carry_zero),
        .cout       (core_cout)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
`ifdef ITER_CNT_EN
            iter_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        state  <= ITER;
                        rsp_id <= gnt_id;
                        rr_ptr <= (gnt_id == IDW'(N - 1)) ? '0 : IDW'(gnt_id + 1'b1);
`ifdef ITER_CNT_EN
                        iter_cnt <= '0;
`endif
                    end
                end
                ITER: begin
`ifdef ITER_CNT_EN
                    if (iter_cnt < ITER_W'(M)) begin
                        iter_cnt <= iter_cnt + 1'b1;
                    end
`endif
                    if (core_carry_zero) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready_i) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_id_o    = rsp_id;
    assign bus.rsp_sum_o   = core_sum;
    assign bus.rsp_cout_o  = core_cout;
`ifdef ITER_CNT_EN
    assign bus.rsp_iter_o  = iter_cnt;
`endif
    assign busy_o          = (state != IDLE);

endmodule
